// File: rtl/rotate_pkg.sv
// Shared definitions for the rotating-box sequencer and its display decoder.
// Holds the position code width, end codes, direction encoding and a step helper.
package rotate_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t STATE_FIRST = 3'b000;
    localparam state_t STATE_LAST  = 3'b111;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Wraps naturally through the full code space in either direction.
    function automatic state_t step_state(input state_t cur, input logic dir);
        state_t nxt;
        if (dir == DIR_REV) begin
            nxt = cur - 1'b1;
        end else begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how long the synchronized input has disagreed with the
    // accepted level; the level flips on the last of DB_CYCLES disagreeing cycles.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/rotate_sequencer.sv
// Rotating-box position sequencer: prescaled forward/backward walk of the eight
// positions with switch synchronizers and push-button run/pause.
module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic               btn_pause,
    output logic [STATE_W-1:0] state,
    output logic               advance,
    output logic               running
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             en_meta_q;
    logic             en_s_q;
    logic             dir_meta_q;
    logic             dir_s_q;

    logic             btn_level_unused;
    logic             btn_press;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    state_t           state_q;
    state_t           state_d;
    logic             advance_q;
    logic             advance_d;
    logic             running_q;
    logic             running_d;

    logic             count_en;
    logic             step;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_pause),
        .level  (btn_level_unused),
        .press  (btn_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_meta_q  <= 1'b0;
            en_s_q     <= 1'b0;
            dir_meta_q <= 1'b0;
            dir_s_q    <= 1'b0;
        end else begin
            en_meta_q  <= en;
            en_s_q     <= en_meta_q;
            dir_meta_q <= dir;
            dir_s_q    <= dir_meta_q;
        end
    end

    // Step decisions use the pre-toggle run flag, so a press landing on a step
    // cycle still lets that step through while pausing from the same edge.
    always_comb begin
        count_en  = en_s_q && running_q;
        step      = count_en && (pre_q == PRE_LAST);
        pre_d     = pre_q;
        state_d   = state_q;
        advance_d = step;
        running_d = running_q ^ btn_press;
        if (count_en) begin
            pre_d = step ? '0 : pre_q + 1'b1;
        end
        if (step) begin
            state_d = step_state(state_q, dir_s_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            state_q   <= STATE_FIRST;
            advance_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            state_q   <= state_d;
            advance_q <= advance_d;
            running_q <= running_d;
        end
    end

    assign state   = state_q;
    assign advance = advance_q;
    assign running = running_q;

endmodule
